// File: rtl/frame_buffer_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_buffer_reader: streams one frame out of a 1-cycle-latency buffer through
// a 2-entry output FIFO. Optional macro: FB_READER_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module frame_buffer_reader #(
  parameter int DEPTH       = 76800,
  parameter int WIDTH       = 15,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                      read_clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      rq_read,
  input  logic                      ack_read,
  output logic                      reading,
  output logic [$clog2(DEPTH)-1:0]  read_addr,
  input  logic [WIDTH-1:0]          rd_px_data,
  output logic [WIDTH-1:0]          out_px_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_REQ     = 2'd1;
  localparam logic [1:0] c_READ    = 2'd2;
  localparam logic [1:0] c_RELEASE = 2'd3;

  localparam logic [CW-1:0] c_LAST     = CW'(DEPTH - 1);
  localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
  localparam logic [AW-1:0] c_ADDR_MAX = AW'(DEPTH - 1);

  logic [1:0]       state_q, state_d;
  logic             rq_q, rq_d;
  logic             reading_q, reading_d;
  logic             done_q, done_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CW-1:0]    issued_q, issued_d;
  logic [CW-1:0]    xfer_q, xfer_d;
  logic             inflight_q, inflight_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] mem_q [2];

`ifdef FB_READER_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] c_TMO_LAST = TW'(ACK_TIMEOUT - 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  logic       w_pop;
  logic       w_issue;
  logic       w_last_xfer;
  logic [1:0] w_occ;

  // Occupancy counts the slot freed by this cycle's pop so streaming has no bubbles.
  assign w_pop       = (count_q != 2'd0) && out_ready;
  assign w_last_xfer = w_pop && (xfer_q == c_LAST);
  assign w_occ       = count_q + {1'b0, inflight_q} - {1'b0, w_pop};
  assign w_issue     = (state_q == c_READ) && ack_read && (w_occ < 2'd2) && (issued_q != c_DEPTH);

  always_comb begin
    state_d    = state_q;
    rq_d       = rq_q;
    reading_d  = reading_q;
    done_d     = 1'b0;
    addr_d     = addr_q;
    issued_d   = issued_q;
    xfer_d     = xfer_q;
    inflight_d = w_issue;
    wr_ptr_d   = wr_ptr_q ^ inflight_q;
    rd_ptr_d   = rd_ptr_q ^ w_pop;
    count_d    = count_q + {1'b0, inflight_q} - {1'b0, w_pop};
`ifdef FB_READER_TIMEOUT_EN
    timer_d    = timer_q;
`endif
    if (w_pop) xfer_d = xfer_q + CW'(1);
    if (w_issue) begin
      issued_d = issued_q + CW'(1);
      if (addr_q != c_ADDR_MAX) addr_d = addr_q + AW'(1);
    end

    case (state_q)
      c_IDLE: begin
        if (start) begin
          state_d = c_REQ;
          rq_d    = 1'b1;
`ifdef FB_READER_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      c_REQ: begin
        if (ack_read) begin
          state_d   = c_READ;
          rq_d      = 1'b0;
          reading_d = 1'b1;
          addr_d    = '0;
          issued_d  = '0;
          xfer_d    = '0;
        end
`ifdef FB_READER_TIMEOUT_EN
        else if (timer_q == c_TMO_LAST) begin
          state_d = c_IDLE;
          rq_d    = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      c_READ: begin
        // Normal end and grant loss both close the session and flush the FIFO.
        if (w_last_xfer || !ack_read) begin
          state_d    = w_last_xfer ? c_RELEASE : c_IDLE;
          reading_d  = 1'b0;
          inflight_d = 1'b0;
          count_d    = 2'd0;
          wr_ptr_d   = 1'b0;
          rd_ptr_d   = 1'b0;
        end
      end
      c_RELEASE: begin
        if (!ack_read) begin
          state_d = c_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge read_clk) begin
    if (reset) begin
      state_q    <= c_IDLE;
      rq_q       <= 1'b0;
      reading_q  <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      issued_q   <= '0;
      xfer_q     <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
`ifdef FB_READER_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rq_q       <= rq_d;
      reading_q  <= reading_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      xfer_q     <= xfer_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef FB_READER_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  always_ff @(posedge read_clk) begin
    if (inflight_q) mem_q[wr_ptr_q] <= rd_px_data;
  end

  assign rq_read     = rq_q;
  assign reading     = reading_q;
  assign read_addr   = addr_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_px_data = mem_q[rd_ptr_q];
  assign out_last    = out_valid && (xfer_q == c_LAST);
  assign busy        = (state_q != c_IDLE);
  assign frame_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_reader.sv
`default_nettype none
// Self-checking bench for frame_buffer_reader (DEPTH=16); buffer model returns addr+100.
module tb_frame_buffer_reader;
  localparam int DEPTH = 16;
  localparam int WIDTH = 15;
  localparam int AW    = 4;
  localparam int NV    = 27;

  logic             read_clk = 1'b0;
  logic             reset, start, ack_read, out_ready;
  logic             rq_read, reading, out_valid, out_last, busy, frame_done;
  logic [AW-1:0]    read_addr;
  logic [WIDTH-1:0] rd_px_data, out_px_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 read_clk = ~read_clk;

  always @(posedge read_clk) rd_px_data <= WIDTH'(read_addr) + WIDTH'(100);

  frame_buffer_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ACK_TIMEOUT(20)) dut (
    .read_clk(read_clk), .reset(reset), .start(start), .rq_read(rq_read),
    .ack_read(ack_read), .reading(reading), .read_addr(read_addr),
    .rd_px_data(rd_px_data), .out_px_data(out_px_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic             start, ack, rdy;
    logic [5:0]       exp_ctrl;   // {rq, reading, busy, valid, last, done}
    logic [AW-1:0]    exp_addr;
    logic [WIDTH-1:0] exp_px;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  function automatic int ctrl_now();
    return int'({rq_read, reading, busy, out_valid, out_last, frame_done});
  endfunction

  task automatic run_frame(input string tag, input logic [31:0] rdy_pat,
                           input int abort_after, input int restart_at, input int exp_n);
    int cyc = 0;
    int n_done = 0;
    bit seen_busy = 0;
    bit fin = 0;
    bit restarted = 0;
    bit pv = 0, pr = 0, pa = 0;
    logic [WIDTH-1:0] ppx = '0;
    logic [WIDTH-1:0] q_px[$];
    bit q_last[$];
    start = 1'b1; ack_read = 1'b0; out_ready = 1'b0;
    tick();
    start = 1'b0;
    while (!fin && cyc < 400) begin
      if (busy) seen_busy = 1;
      if (pv && !pr && pa) begin
        check($sformatf("%s_hold_valid_c%0d", tag, cyc), int'(out_valid), 1);
        check($sformatf("%s_hold_px_c%0d", tag, cyc), int'(out_px_data), int'(ppx));
      end
      out_ready = rdy_pat[cyc % 32];
      start = 1'b0;
      if (restart_at >= 0 && !restarted && q_px.size() == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (rq_read) ack_read = 1'b1;
      if (q_last.size() > 0 && q_last[$]) ack_read = 1'b0;
      if (abort_after > 0 && q_px.size() >= abort_after) begin
        ack_read = 1'b0;
        out_ready = 1'b0;
      end
      if (out_valid && out_ready) begin
        q_px.push_back(out_px_data);
        q_last.push_back(out_last);
      end
      if (frame_done) n_done++;
      pv = out_valid; pr = out_ready; pa = ack_read; ppx = out_px_data;
      if (seen_busy && !busy) begin
        fin = 1;
        check({tag, "_end_reading_valid"}, int'({reading, out_valid}), 0);
      end else begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    if (!fin) check({tag, "_session_end_timeout"}, 0, 1);
    check({tag, "_xfer_count"}, q_px.size(), exp_n);
    for (int i = 0; i < q_px.size() && i < exp_n; i++) begin
      check($sformatf("%s_px[%0d]", tag, i), int'(q_px[i]), 100 + i);
      check($sformatf("%s_last[%0d]", tag, i), int'(q_last[i]), (i == DEPTH - 1) ? 1 : 0);
    end
    check({tag, "_frame_done_pulses"}, n_done, (abort_after > 0) ? 0 : 1);
    ack_read = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("%s_idle_after[%0d]", tag, k), ctrl_now(), 0);
    end
  endtask

  initial begin
    int n;
    int k;
    for (int c = 0; c < NV; c++) begin
      vecs[c].start    = (c == 0);
      vecs[c].ack      = (c >= 4 && c <= 23);
      vecs[c].rdy      = 1'b1;
      vecs[c].exp_ctrl = {(c >= 1 && c <= 4), (c >= 5 && c <= 22), (c >= 1 && c <= 24),
                          (c >= 7 && c <= 22), (c == 22), (c == 25)};
      vecs[c].exp_addr = AW'((c < 5) ? 0 : (c > 20) ? 15 : c - 5);
      vecs[c].exp_px   = WIDTH'(100 + c - 7);
    end

    reset = 1'b1; start = 1'b0; ack_read = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge read_clk);
    #1;
    reset = 1'b0;

    // Nominal frame: ack 3 cycles after rq_read, downstream always ready.
    for (int i = 0; i < NV; i++) begin
      start = vecs[i].start; ack_read = vecs[i].ack; out_ready = vecs[i].rdy;
      check($sformatf("nom_ctrl[%0d]", i), ctrl_now(), int'(vecs[i].exp_ctrl));
      check($sformatf("nom_addr[%0d]", i), int'(read_addr), int'(vecs[i].exp_addr));
      if (vecs[i].exp_ctrl[2])
        check($sformatf("nom_px[%0d]", i), int'(out_px_data), int'(vecs[i].exp_px));
      tick();
    end

    run_frame("bp", 32'h9D3A_5C6B, -1, -1, 16);
    run_frame("restart", 32'hFFFF_FFFF, -1, 4, 16);
    run_frame("abort", 32'hFFFF_FFFF, 5, -1, 5);

    // Reset while pixel 8 is at the FIFO head.
    start = 1'b1; ack_read = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0; k = 0;
    while (n < 8 && k < 100) begin
      if (rq_read) ack_read = 1'b1;
      if (out_valid && out_ready) n++;
      tick();
      k++;
    end
    check("rst_reach_px8", n, 8);
    check("rst_head_px8", int'(out_px_data), 108);
    reset = 1'b1;
    tick();
    check("rst_ctrl_zero", ctrl_now(), 0);
    check("rst_addr_zero", int'(read_addr), 0);
    reset = 1'b0; ack_read = 1'b0;
    tick();
    run_frame("after_rst", 32'hFFFF_FFFF, -1, -1, 16);

`ifdef FB_READER_TIMEOUT_EN
    start = 1'b1; ack_read = 1'b0;
    tick();
    start = 1'b0;
    n = 0; k = 0;
    while (rq_read && k < 100) begin
      if (frame_done) k = k + 1000;
      n++;
      tick();
      k++;
    end
    check("tmo_rq_cycles", n, 20);
    check("tmo_ctrl_idle", ctrl_now(), 0);
    tick();
    check("tmo_ctrl_idle_next", ctrl_now(), 0);
`else
    start = 1'b1; ack_read = 1'b0;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("wait_rq_held", int'(rq_read), 1);
    check("wait_busy_held", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wait_reset_idle", ctrl_now(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_buffer_reader.md
FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 76800: pixels per frame and buffer depth.
REQ-002 SHALL have parameter WIDTH, default 15: pixel width in bits.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1024: maximum cycles to wait for ack_read (used only under REQ-030).
REQ-004 read_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to read one full frame.
REQ-007 rq_read  out  1  read request to the frame buffer.
REQ-008 ack_read  in  1  read grant from the frame buffer.
REQ-009 reading  out  1  read session active; its falling edge releases the buffer.
REQ-010 read_addr  out  clog2(DEPTH)  pixel address to the buffer read port.
REQ-011 rd_px_data  in  WIDTH  buffer data, valid one cycle after read_addr.
REQ-012 out_px_data  out  WIDTH  pixel to downstream.
REQ-013 out_valid  out  1  out_px_data is valid.
REQ-014 out_ready  in  1  downstream accepts; transfer occurs when out_valid and out_ready are both high.
REQ-015 out_last  out  1  high with the pixel at index DEPTH-1.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 frame_done  out  1  one-cycle pulse when a frame session closes normally.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, READ, RELEASE.
REQ-019 IDLE: start SHALL move the FSM to REQ; start SHALL be ignored in every other state.
REQ-020 REQ: rq_read SHALL be 1; on ack_read=1, rq_read SHALL drop to 0, reading SHALL rise to 1, read_addr SHALL be 0, and the FSM SHALL move to READ.
REQ-021 READ: the block SHALL issue address k when (buffered entries + in-flight reads) < 2, incrementing k from 0 to DEPTH-1, issuing each address exactly once.
REQ-022 A 2-entry output FIFO SHALL capture rd_px_data on the cycle after each issue and SHALL drive the head on out_px_data/out_valid.
REQ-023 Latency: with out_ready=1, the first out_valid SHALL occur 2 cycles after READ entry, followed by one pixel per cycle with no bubbles.
REQ-024 Backpressure: while out_ready=0, out_px_data SHALL hold, no pixel SHALL be lost or duplicated, and issue SHALL stall once the FIFO is full.
REQ-025 After the DEPTH-th transfer (out_last accepted), reading SHALL drop to 0 on the next edge and the FSM SHALL enter RELEASE.
REQ-026 RELEASE: on ack_read=0, the FSM SHALL pulse frame_done for one cycle and return to IDLE.
REQ-027 If ack_read falls in READ before the last transfer, the FSM SHALL abort: reading drops to 0, the FIFO is flushed, no frame_done is pulsed, and the FSM returns to IDLE.
REQ-028 read_addr SHALL never exceed DEPTH-1 and SHALL hold its last value when no address is issued.

Reset
REQ-029 On reset the FSM SHALL enter IDLE and, on the next edge, rq_read, reading, out_valid, out_last, busy, frame_done, read_addr and the counters SHALL all be 0 and the FIFO empty; reset mid-frame SHALL abandon the frame.

Configuration
REQ-030 With FB_READER_TIMEOUT_EN defined, REQ SHALL count cycles and, after ACK_TIMEOUT cycles without ack_read, SHALL drop rq_read and return to IDLE with no frame_done; without the macro, REQ SHALL wait indefinitely.

Verification (DEPTH=16, WIDTH=15, buffer model with 1-cycle read latency, data = addr+100)
REQ-031 start; ack_read 3 cycles after rq_read; out_ready=1 -> 16 pixels 100..115 on consecutive cycles, out_last on 115, reading falls, frame_done 1 cycle after ack_read falls.
REQ-032 out_ready toggled with a pseudo-random pattern -> exactly 100..115 in order, with no duplicates or gaps.
REQ-033 ack_read dropped after 5 transfers -> reading=0, out_valid=0, no frame_done, busy=0.
REQ-034 reset asserted during READ at pixel 8 -> all outputs 0 next edge; a new start reads a full frame from address 0.
REQ-035 start pulsed during READ -> ignored; exactly one frame delivered.
REQ-036 FB_READER_TIMEOUT_EN defined, ACK_TIMEOUT=20, ack_read never asserted -> rq_read drops after 20 cycles, FSM returns to IDLE, frame_done=0.
